// File: rtl/fm_radio_pkg.sv
// Shared constants, FSM state encoding and the dequantize helper for the FM radio chain.
package fm_radio_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int BITS       = 10;
    localparam int QUANT      = 1 << BITS;

    localparam logic signed [DATA_WIDTH-1:0] QUAD1 = 804;
    localparam logic signed [DATA_WIDTH-1:0] QUAD3 = 2412;
    localparam logic signed [DATA_WIDTH-1:0] GAIN  = 758;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_ANGLE,
        S_GAIN,
        S_OUT
    } state_t;

    // Divide by QUANT rounding toward zero, keeping the low 32 bits of the result.
    function automatic logic signed [DATA_WIDTH-1:0] trunc0(input logic signed [2*DATA_WIDTH-1:0] v);
        logic signed [2*DATA_WIDTH-1:0] adj;
        adj = v;
        if (v[2*DATA_WIDTH-1]) begin
            adj = v + 64'(QUANT - 1);
        end
        adj = adj >>> BITS;
        return adj[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first, 32 iterations after start.
module seq_divider
    import fm_radio_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient
);

    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] div_q, div_d;
    logic [5:0]            cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH:0]   diff;

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        trial  = {rem_q, quo_q[DATA_WIDTH-1]};
        diff   = trial - {1'b0, div_q};
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            div_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Remainder stays below the divisor, so a clear borrow bit means trial >= divisor.
            if (!diff[DATA_WIDTH]) begin
                rem_d = diff[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = trial[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // High during the final iteration; quotient holds the full result from the next cycle.
    assign done     = busy_q && (cnt_q == 6'd31);
    assign quotient = quo_q;

endmodule

// File: rtl/qarctan_demod.sv
// Quadrant-approximated arctangent FM demodulator: one gain-scaled audio sample per IQ pair.
// Define QARCTAN_DEMOD_SAT_EN to clamp each output sample to the signed 16-bit range.
module qarctan_demod
    import fm_radio_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in_real_rd_en,
    input  logic                  in_real_empty,
    input  logic [DATA_WIDTH-1:0] in_real_dout,
    output logic                  in_imag_rd_en,
    input  logic                  in_imag_empty,
    input  logic [DATA_WIDTH-1:0] in_imag_dout,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_din
);

    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic signed [DATA_WIDTH-1:0] base_q, base_d;
    logic signed [DATA_WIDTH-1:0] angle_q, angle_d;
    logic signed [DATA_WIDTH-1:0] result_q, result_d;
    logic                         num_neg_q, num_neg_d;
    logic                         y_neg_q, y_neg_d;

    logic                         pop, div_start, div_done;
    logic [DATA_WIDTH-1:0]        div_num, div_den, div_quot;
    logic signed [DATA_WIDTH-1:0] abs_y, num, den, r, gained;

`ifdef QARCTAN_DEMOD_SAT_EN
    function automatic logic signed [DATA_WIDTH-1:0] sat16(input logic signed [DATA_WIDTH-1:0] v);
        if (v > 32'sd32767) return 32'sd32767;
        if (v < -32'sd32768) return -32'sd32768;
        return v;
    endfunction
`endif

    seq_divider u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_num),
        .divisor  (div_den),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!in_real_empty && !in_imag_empty) state_d = S_PREP;
            S_PREP:  state_d = S_DIV;
            S_DIV:   if (div_done) state_d = S_ANGLE;
            S_ANGLE: state_d = S_GAIN;
            S_GAIN:  state_d = S_OUT;
            S_OUT:   if (!out_full) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Gating with reset keeps the FIFO strobes low for the whole reset window.
    always_comb begin
        pop           = reset && (state_q == S_IDLE) && !in_real_empty && !in_imag_empty;
        in_real_rd_en = pop;
        in_imag_rd_en = pop;
        out_wr_en     = reset && (state_q == S_OUT) && !out_full;
        div_start     = (state_q == S_PREP);
        out_din       = result_q;
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        base_d    = base_q;
        num_neg_d = num_neg_q;
        y_neg_d   = y_neg_q;
        angle_d   = angle_q;
        result_d  = result_q;

        abs_y = (y_q[DATA_WIDTH-1] ? -y_q : y_q) + 32'sd1;
        if (!x_q[DATA_WIDTH-1]) begin
            num = (x_q - abs_y) <<< BITS;
            den = x_q + abs_y;
        end else begin
            num = (x_q + abs_y) <<< BITS;
            den = abs_y - x_q;
        end
        div_num = num[DATA_WIDTH-1] ? -num : num;
        div_den = den;
        r       = num_neg_q ? -div_quot : div_quot;
        gained  = trunc0(64'(GAIN) * 64'(angle_q));

        if (pop) begin
            x_d = in_real_dout;
            y_d = in_imag_dout;
        end
        if (state_q == S_PREP) begin
            base_d    = x_q[DATA_WIDTH-1] ? QUAD3 : QUAD1;
            num_neg_d = num[DATA_WIDTH-1];
            y_neg_d   = y_q[DATA_WIDTH-1];
        end
        if (state_q == S_ANGLE) begin
            angle_d = base_q - trunc0(64'(QUAD1) * 64'(r));
            if (y_neg_q) angle_d = -angle_d;
        end
        if (state_q == S_GAIN) begin
`ifdef QARCTAN_DEMOD_SAT_EN
            result_d = sat16(gained);
`else
            result_d = gained;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q       <= '0;
            y_q       <= '0;
            base_q    <= '0;
            num_neg_q <= 1'b0;
            y_neg_q   <= 1'b0;
            angle_q   <= '0;
            result_q  <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            base_q    <= base_d;
            num_neg_q <= num_neg_d;
            y_neg_q   <= y_neg_d;
            angle_q   <= angle_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_qarctan_demod.sv
// Directed bench for qarctan_demod: FWFT FIFO models on the inputs, write logger on the output.
module tb_qarctan_demod;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_real_rd_en, in_real_empty, in_imag_rd_en, in_imag_empty;
    logic [31:0] in_real_dout, in_imag_dout;
    logic        out_wr_en;
    logic        out_full = 1'b0;
    logic [31:0] out_din;

    logic signed [31:0] fx [0:63];
    logic signed [31:0] fy [0:63];
    int wr_idx = 0;
    int rd_r = 0;
    int rd_i = 0;
    int cyc = 0;
    int pop_n = 0;
    int pop_in = 0;
    int wr_count = 0;
    int pop_cyc [0:63];
    int wr_cyc [0:63];
    logic [31:0] wr_data [0:63];
    bit pend_r = 0;
    bit pend_i = 0;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    qarctan_demod dut (
        .reset         (reset),
        .clock         (clock),
        .in_real_rd_en (in_real_rd_en),
        .in_real_empty (in_real_empty),
        .in_real_dout  (in_real_dout),
        .in_imag_rd_en (in_imag_rd_en),
        .in_imag_empty (in_imag_empty),
        .in_imag_dout  (in_imag_dout),
        .out_wr_en     (out_wr_en),
        .out_full      (out_full),
        .out_din       (out_din)
    );

    assign in_real_empty = (rd_r >= wr_idx);
    assign in_imag_empty = (rd_i >= wr_idx);
    assign in_real_dout  = fx[rd_r];
    assign in_imag_dout  = fy[rd_i];

    always @(negedge clock) begin
        pend_r = in_real_rd_en;
        pend_i = in_imag_rd_en;
        if (in_real_rd_en) begin
            pop_cyc[pop_n] = cyc;
            pop_n++;
        end
        if (in_imag_rd_en) pop_in++;
        if (out_wr_en) begin
            wr_data[wr_count] = out_din;
            wr_cyc[wr_count]  = cyc;
            wr_count++;
        end
    end

    always @(posedge clock) begin
        cyc++;
        #1;
        if (pend_r) rd_r++;
        if (pend_i) rd_i++;
    end

    task automatic push(input logic signed [31:0] x, input logic signed [31:0] y);
        fx[wr_idx] = x;
        fy[wr_idx] = y;
        wr_idx++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_write(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (!ok) begin
                if (wr_count >= target) ok = 1;
                else step(1);
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL write_timeout: writes=%0d required=%0d", wr_count, target);
        end
    endtask

    task automatic run_vec(input string name, input logic signed [31:0] x,
                           input logic signed [31:0] y, input logic signed [31:0] exp_out);
        int w0, p0, q0;
        bit ok;
        w0 = wr_count;
        p0 = pop_n;
        q0 = pop_in;
        push(x, y);
        wait_write(w0 + 1, ok);
        if (ok) begin
            checks++;
            if (wr_data[w0] !== exp_out) begin
                errors++;
                $display("FAIL %s_value: got=%0d required=%0d", name, $signed(wr_data[w0]), exp_out);
            end
            checks++;
            if (wr_cyc[w0] - pop_cyc[p0] !== 36) begin
                errors++;
                $display("FAIL %s_latency: got=%0d required=36", name, wr_cyc[w0] - pop_cyc[p0]);
            end
        end
        step(3);
        checks++;
        if (pop_n - p0 !== 1 || pop_in - q0 !== 1) begin
            errors++;
            $display("FAIL %s_pops: real=%0d imag=%0d required=1/1", name, pop_n - p0, pop_in - q0);
        end
    endtask

    task automatic test_reset;
        bit ok;
        push(32'sd1024, 32'sd0);
        step(3);
        checks++;
        if (in_real_rd_en !== 1'b0 || in_imag_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_en: got=%b%b required=00", in_real_rd_en, in_imag_rd_en);
        end
        checks++;
        if (out_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_en: got=%b required=0", out_wr_en);
        end
        checks++;
        if (out_din !== 32'd0) begin
            errors++;
            $display("FAIL reset_out_din: got=%0d required=0", out_din);
        end
        reset = 1'b1;
        wait_write(1, ok);
        if (ok) begin
            checks++;
            if (wr_data[0] !== 32'sd1) begin
                errors++;
                $display("FAIL x1024_y0_value: got=%0d required=1", $signed(wr_data[0]));
            end
            checks++;
            if (wr_cyc[0] - pop_cyc[0] !== 36) begin
                errors++;
                $display("FAIL x1024_y0_latency: got=%0d required=36", wr_cyc[0] - pop_cyc[0]);
            end
        end
        step(3);
    endtask

    task automatic test_quadrants;
        run_vec("x0_y1024",  32'sd0,     32'sd1024,  32'sd1190);
        run_vec("x0_yn1024", 32'sd0,     -32'sd1024, -32'sd1190);
        run_vec("xn1024_y0", -32'sd1024, 32'sd0,     32'sd2379);
    endtask

    task automatic test_back_to_back;
        int w0, p0;
        bit ok;
        w0 = wr_count;
        p0 = pop_n;
        push(32'sd1000, 32'sd500);
        push(-32'sd300, -32'sd700);
        wait_write(w0 + 2, ok);
        if (ok) begin
            checks++;
            if (wr_data[w0] !== 32'sd398) begin
                errors++;
                $display("FAIL b2b_first: got=%0d required=398", $signed(wr_data[w0]));
            end
            checks++;
            if (wr_data[w0+1] !== -32'sd1547) begin
                errors++;
                $display("FAIL b2b_second: got=%0d required=-1547", $signed(wr_data[w0+1]));
            end
            checks++;
            if (pop_cyc[p0+1] - pop_cyc[p0] !== 37) begin
                errors++;
                $display("FAIL b2b_pop_spacing: got=%0d required=37", pop_cyc[p0+1] - pop_cyc[p0]);
            end
        end
        step(3);
    endtask

    task automatic test_backpressure;
        int w0, p0;
        bit ok;
        w0 = wr_count;
        p0 = pop_n;
        out_full = 1'b1;
        push(32'sd0, 32'sd1024);
        push(-32'sd1024, 32'sd0);
        step(45);
        checks++;
        if (wr_count !== w0) begin
            errors++;
            $display("FAIL bp_early_write: writes=%0d required=%0d", wr_count - w0, 0);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (out_wr_en !== 1'b0 || in_real_rd_en !== 1'b0 || in_imag_rd_en !== 1'b0 ||
                out_din !== 32'sd1190) begin
                errors++;
                $display("FAIL bp_hold[%0d]: wr=%b rd=%b%b din=%0d required wr=0 rd=00 din=1190",
                         i, out_wr_en, in_real_rd_en, in_imag_rd_en, $signed(out_din));
            end
            step(1);
        end
        checks++;
        if (pop_n - p0 !== 1) begin
            errors++;
            $display("FAIL bp_hold_pops: got=%0d required=1", pop_n - p0);
        end
        out_full = 1'b0;
        wait_write(w0 + 2, ok);
        if (ok) begin
            checks++;
            if (wr_data[w0] !== 32'sd1190) begin
                errors++;
                $display("FAIL bp_release_value: got=%0d required=1190", $signed(wr_data[w0]));
            end
            checks++;
            if (wr_data[w0+1] !== 32'sd2379) begin
                errors++;
                $display("FAIL bp_next_value: got=%0d required=2379", $signed(wr_data[w0+1]));
            end
        end
        step(3);
    endtask

    task automatic test_reset_mid_div;
        int w0, p0, q0;
        bit ok;
        w0 = wr_count;
        p0 = pop_n;
        q0 = pop_in;
        push(32'sd0, -32'sd1024);
        step(16);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (in_real_rd_en !== 1'b0 || in_imag_rd_en !== 1'b0 || out_wr_en !== 1'b0 ||
            out_din !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: rd=%b%b wr=%b din=%0d required 00/0/0",
                     in_real_rd_en, in_imag_rd_en, out_wr_en, $signed(out_din));
        end
        push(32'sd1000, 32'sd500);
        step(1);
        checks++;
        if (in_real_rd_en !== 1'b0 || in_imag_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_rd_gate: got=%b%b required=00", in_real_rd_en, in_imag_rd_en);
        end
        reset = 1'b1;
        wait_write(w0 + 1, ok);
        if (ok) begin
            checks++;
            if (wr_data[w0] !== 32'sd398) begin
                errors++;
                $display("FAIL mid_reset_next_value: got=%0d required=398", $signed(wr_data[w0]));
            end
            checks++;
            if (wr_cyc[w0] - pop_cyc[p0+1] !== 36) begin
                errors++;
                $display("FAIL mid_reset_latency: got=%0d required=36", wr_cyc[w0] - pop_cyc[p0+1]);
            end
        end
        step(50);
        checks++;
        if (wr_count !== w0 + 1) begin
            errors++;
            $display("FAIL mid_reset_write_count: got=%0d required=1", wr_count - w0);
        end
        checks++;
        if (pop_n - p0 !== 2 || pop_in - q0 !== 2) begin
            errors++;
            $display("FAIL mid_reset_pops: real=%0d imag=%0d required=2/2", pop_n - p0, pop_in - q0);
        end
    endtask

    initial begin
        test_reset();
        test_quadrants();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
